// File: rtl/div_radix.sv
// rtl/div_radix.sv - Iterative radix-2^k integer divider (RISC-V DIV/DIVU/REM/REMU, optional W variants)
//
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   flush                 abort any in-flight operation (wins over accept and out_ready)
//   in_valid / in_ready   operation handshake; in1 = dividend, in2 = divisor, op, word
//   out_valid / out_ready result handshake; out = quotient or remainder
module div_radix #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 2,
    parameter int WORD_EN        = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [1:0]      op,
    input  logic            word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN / BITS_PER_CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32 / BITS_PER_CYCLE - 1);
    localparam logic [6:0]       SH_WORD  = 7'(XLEN - 32);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    rem_q, quo_q, dvs_q;
    logic               neg_q, neg_r, sel_rem, word_q;

    // Sign-extend bit 31 up to XLEN when the op is a W variant.
    function automatic logic [XLEN-1:0] fix_word(input logic [XLEN-1:0] v, input logic wm);
        logic signed [XLEN-1:0] t;
        t = v << SH_WORD;
        t = t >>> SH_WORD;
        return wm ? XLEN'(t) : v;
    endfunction

    // ---------------- operand preparation ----------------
    logic                   word_mode, is_signed, a_neg, b_neg, div_zero, ovf, special, accept;
    logic [6:0]             sh;
    logic [XLEN-1:0]        a_sh, b_sh, a_ext, b_ext, a_mag, b_mag, min_w, special_res;
    logic signed [XLEN-1:0] a_s, b_s;

    always_comb begin
        word_mode = (WORD_EN != 0) && word;
        is_signed = ~op[0];
        sh        = word_mode ? SH_WORD : 7'd0;
        // Shift the W-bit operand to the top, then back down to extend it.
        a_sh      = in1 << sh;
        b_sh      = in2 << sh;
        a_s       = a_sh;
        b_s       = b_sh;
        a_s       = a_s >>> sh;
        b_s       = b_s >>> sh;
        a_ext     = is_signed ? XLEN'(a_s) : (a_sh >> sh);
        b_ext     = is_signed ? XLEN'(b_s) : (b_sh >> sh);
        a_neg     = is_signed && a_ext[XLEN-1];
        b_neg     = is_signed && b_ext[XLEN-1];
        a_mag     = a_neg ? -a_ext : a_ext;
        b_mag     = b_neg ? -b_ext : b_ext;
        min_w     = {XLEN{1'b1}} << (word_mode ? 31 : XLEN - 1);
        div_zero  = (b_ext == '0);
        ovf       = is_signed && (a_ext == min_w) && (b_ext == {XLEN{1'b1}});
        special   = div_zero || ovf;
        if (op[1])
            special_res = div_zero ? a_ext : '0;
        else
            special_res = div_zero ? {XLEN{1'b1}} : a_ext;
        special_res = fix_word(special_res, word_mode);
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN-1:0] rem_s, quo_s, calc_res;
    logic [XLEN:0]   trial;

    // The dividend is MSB-aligned in quo_q and shifted out one bit per step
    // while quotient bits shift in at the bottom (restoring division).
    always_comb begin
        rem_s = rem_q;
        quo_s = quo_q;
        trial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial = {rem_s, quo_s[XLEN-1]};
            quo_s = {quo_s[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial    = trial - {1'b0, dvs_q};
                quo_s[0] = 1'b1;
            end
            rem_s = trial[XLEN-1:0];
        end
        if (sel_rem)
            calc_res = neg_r ? -rem_s : rem_s;
        else
            calc_res = neg_q ? -quo_s : quo_s;
        calc_res = fix_word(calc_res, word_q);
    end

    // ---------------- control ----------------
    assign in_ready  = reset_n && ((state == S_IDLE) || (state == S_DONE && out_ready));
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == '0) state_nx = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    if (accept) state_nx = special ? S_DONE : S_CALC;
                    else        state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            out     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            word_q  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rem_q   <= '0;
                quo_q   <= a_mag << sh;
                dvs_q   <= b_mag;
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                sel_rem <= op[1];
                word_q  <= word_mode;
                cnt     <= word_mode ? CNT_WORD : CNT_FULL;
                if (special) out <= special_res;
            end else if (state == S_CALC) begin
                rem_q <= rem_s;
                quo_q <= quo_s;
                if (cnt == '0) out <= calc_res;
                else           cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_radix.sv
// tb/tb_div_radix.sv - Directed vector bench for div_radix (XLEN=64, 2 bits/cycle, word mode)
module tb_div_radix;

    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    logic        clock = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, word, out_valid, out_ready;
    logic [63:0] in1, in2, out;
    logic [1:0]  op;

    int errors = 0;
    int checks = 0;

    div_radix #(.XLEN(64), .BITS_PER_CYCLE(2), .WORD_EN(1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .word(word),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wait for out_valid counting cycles from the accepting edge (cycle 1 = just after it).
    task automatic wait_result(input string name, input logic [63:0] exp, input int lat);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({name, "_out"}, out, exp);
        check({name, "_lat"}, 64'(cyc), 64'(lat));
    endtask

    task automatic present(input vec_t v);
        op = v.op; word = v.word; in1 = v.a; in2 = v.b; in_valid = 1'b1;
    endtask

    task automatic scramble_inputs();
        in_valid = 1'b0; in1 = 64'h0123_4567_89AB_CDEF; in2 = 64'h5; op = REMU; word = 1'b1;
    endtask

    task automatic run_op(input vec_t v);
        present(v);
        @(posedge clock); #1;
        scramble_inputs();
        wait_result(v.name, v.exp, v.lat);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        bit   seen;

        vecs[0]  = '{"div_m7_2",    DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[1]  = '{"rem_m7_2",    REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[2]  = '{"divu_by0",    DIVU, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[3]  = '{"remu_by0",    REMU, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 1};
        vecs[4]  = '{"div_ovf",     DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[5]  = '{"divw_ovf",    DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[6]  = '{"divuw",       DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0002, 64'h0000_0000_7FFF_FFFF, 17};
        vecs[7]  = '{"remu_100_7",  REMU, 1'b0, 64'd100, 64'd7, 64'd2, 33};
        vecs[8]  = '{"divu_max",    DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[9]  = '{"remw_m7_2",   REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 17};
        vecs[10] = '{"div_100_m7",  DIV,  1'b0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 33};
        vecs[11] = '{"rem_100_m7",  REM,  1'b0, 64'd100, -64'sd7, 64'd2, 33};
        vecs[12] = '{"remw_by0",    REM,  1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1};
        vecs[13] = '{"divuw_sext",  DIVU, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 17};

        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out", out, 64'd0);
        reset_n = 1'b1;
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clock); #1;

        for (int i = 0; i < 14; i++) run_op(vecs[i]);

        // Backpressure: result must hold, then a new op is taken with out_ready, no bubble.
        v = '{"bp_divu", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 33};
        present(v);
        @(posedge clock); #1;
        scramble_inputs();
        wait_result(v.name, v.exp, v.lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("bp_hold_out", out, 64'd14);
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        v = vecs[11];
        present(v);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clock); #1;
        scramble_inputs();
        out_ready = 1'b0;
        check("bp_next_calc", {63'd0, out_valid}, 64'd0);
        wait_result("bp_next", v.exp, v.lat);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;

        // Flush in CALC with a (divide-by-zero) op presented alongside.
        present(vecs[7]);
        @(posedge clock); #1;
        scramble_inputs();
        repeat (10) @(posedge clock);
        #1;
        present(vecs[2]);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        scramble_inputs();
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_idle", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", {63'd0, seen}, 64'd0);
        run_op(vecs[10]);

        // Reset mid-CALC: out must return to 0 (it holds a nonzero result now).
        present(vecs[8]);
        @(posedge clock); #1;
        scramble_inputs();
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("rstmid_out", out, 64'd0);
        check("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
        reset_n = 1'b1;
        #1;
        run_op(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_radix.md
Name: div_radix

Overview:
- Parametrised iterative integer divider for the execute stage; next generation of the single-rate `div` unit.
- Configurable XLEN, radix (quotient bits retired per cycle) and optional 32-bit word mode.
- Valid/ready handshake on both sides and a flush input.
- RISC-V divide-by-zero and signed-overflow cases bypass iteration and complete in one cycle.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- BITS_PER_CYCLE, 2, quotient bits produced per iteration cycle; legal values 1, 2, 4.
- WORD_EN, 1, when 1 the `word` input selects 32-bit ops; when 0 `word` is ignored. Must be 0 if XLEN=32.

Ports:
- clock  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous abort; drops any in-flight operation.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  divider can accept an operation this cycle.
- in1  input  XLEN  dividend.
- in2  input  XLEN  divisor.
- op  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- word  input  1  W-variant (DIVW/DIVUW/REMW/REMUW).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result this cycle.
- out  output  XLEN  result.

Behaviour:
- Reset (reset_n=0 at clock edge): state=IDLE, out=0, out_valid=0, counter=0. in_ready=0 while reset_n=0.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). An accept is in_valid && in_ready && !flush.
- Operand preparation on accept:
  - W = 32 if (WORD_EN && word), else XLEN.
  - Signed ops (DIV, REM) take the low W bits sign-extended; unsigned ops take the low W bits zero-extended.
  - Operands are converted to magnitude. Quotient sign = sign(in1) XOR sign(in2). Remainder sign = sign(in1).
- Special cases, detected on the W-bit values at accept; next state DONE, no iteration:
  - Divisor zero: quotient = all ones (-1); remainder = dividend.
  - Signed overflow (dividend = -2^(W-1), divisor = -1): quotient = dividend; remainder = 0.
- Normal path: next state CALC, counter = N-1, where N = W/BITS_PER_CYCLE.
  - Each CALC cycle performs BITS_PER_CYCLE chained restoring shift-subtract steps on the partial remainder and quotient.
  - When counter==0 the next state is DONE; otherwise the counter decrements.
- DONE:
  - Result is the quotient (DIV/DIVU) or remainder (REM/REMU), sign-corrected, registered into `out` on the transition into DONE.
  - In word mode the 32-bit result is sign-extended to XLEN for all four ops.
  - out_valid=1 while in DONE.
- Latency, counted from the accepting edge to out_valid high:
  - Normal: N+1 cycles. XLEN=64, R=2: 33 cycles (word: 17).
  - Special case: 1 cycle.
- Output hold: while out_valid && !out_ready, `out` is stable and the state stays DONE.
- On out_ready in DONE:
  - With a simultaneous accept, proceed directly to CALC (or DONE for a special case); no bubble.
  - Otherwise go to IDLE and drop out_valid next cycle.
- Flush: has priority over accept and out_ready. Next state is IDLE, out_valid=0 next cycle, counter cleared. `out` value is don't-care but not X. An op presented with flush is not accepted.
- Reset mid-operation: same as flush plus out=0.
- Operands are latched at accept; in1/in2/op/word may change freely during CALC/DONE.

Test Plan:
- XLEN=64, R=2, DIV in1=-7, in2=2 -> out_valid at cycle 33, out=-3 (0xFFFF_FFFF_FFFF_FFFD). REM of the same operands -> out=-1.
- DIVU in1=0x8000_0000_0000_0000, in2=0 -> out_valid next cycle, out=0xFFFF_FFFF_FFFF_FFFF. REMU of the same -> out=in1.
- DIV in1=0x8000_0000_0000_0000, in2=-1 -> 1-cycle, out=0x8000_0000_0000_0000. DIVW in1=0x0000_0000_8000_0000, in2=0xFFFF_FFFF -> out=0xFFFF_FFFF_8000_0000.
- DIVUW in1=0xFFFF_FFFF_FFFF_FFFE, in2=0x1_0000_0002 -> W=32, 0xFFFF_FFFE/2 = 0x7FFF_FFFF, out=0x0000_0000_7FFF_FFFF, out_valid at cycle 17.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> out stable, in_ready=0. Raise out_ready with a new in_valid -> new op accepted the same cycle, no IDLE bubble.
- Flush at CALC cycle 10 with in_valid=1 -> state IDLE next cycle, no out_valid, new op not accepted. A following op completes with correct result. Repeat with reset_n=0 mid-CALC -> out=0, out_valid=0.
